// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master (IFU / LSU) to one-slave memory port arbiter with
//            response pass-through and a DATA-phase timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter bit RR      = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req_valid,
    output logic                 m0_req_ready,
    input  logic [WIDTH-1:0]     m0_addr,
    input  logic                 m0_wen,
    input  logic [WIDTH-1:0]     m0_wdata,
    input  logic [WIDTH/8-1:0]   m0_wmask,
    output logic                 m0_resp_valid,
    input  logic                 m0_resp_ready,
    output logic [WIDTH-1:0]     m0_rdata,
    output logic                 m0_err,

    input  logic                 m1_req_valid,
    output logic                 m1_req_ready,
    input  logic [WIDTH-1:0]     m1_addr,
    input  logic                 m1_wen,
    input  logic [WIDTH-1:0]     m1_wdata,
    input  logic [WIDTH/8-1:0]   m1_wmask,
    output logic                 m1_resp_valid,
    input  logic                 m1_resp_ready,
    output logic [WIDTH-1:0]     m1_rdata,
    output logic                 m1_err,

    output logic                 s_req_valid,
    input  logic                 s_req_ready,
    output logic [WIDTH-1:0]     s_addr,
    output logic                 s_wen,
    output logic [WIDTH-1:0]     s_wdata,
    output logic [WIDTH/8-1:0]   s_wmask,
    input  logic                 s_resp_valid,
    output logic                 s_resp_ready,
    input  logic [WIDTH-1:0]     s_rdata,
    input  logic                 s_err,

    output logic [1:0]           grant
);

    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_addr = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_terr = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic                r_owner;
    logic                r_last;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [WIDTH-1:0]    r_addr;
    logic                r_wen;
    logic [WIDTH-1:0]    r_wdata;
    logic [WIDTH/8-1:0]  r_wmask;

    logic                w_any;
    logic                w_win;
    logic                w_hs;
    logic                w_own_rready;
    logic                w_resp_done;
    logic                w_terr_done;
    logic                w_tmo;
    logic                w_rvalid;
    logic [WIDTH-1:0]    w_rdata;
    logic                w_err;

    // Winner selection; on a tie round-robin favours whoever was not served last.
    always_comb begin
        w_any = m0_req_valid | m1_req_valid;
        if (m0_req_valid & m1_req_valid)
            w_win = RR ? ~r_last : 1'b1;
        else
            w_win = m1_req_valid;
        w_hs         = (r_state == c_st_idle) & w_any & ~rst;
        w_own_rready = r_owner ? m1_resp_ready : m0_resp_ready;
        w_resp_done  = (r_state == c_st_data) & s_resp_valid & w_own_rready;
        w_terr_done  = (r_state == c_st_terr) & w_own_rready;
        w_tmo        = (TIMEOUT != 0) && (r_cnt == c_tmo_last);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_st_idle;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_hs)        w_next = c_st_addr;
            c_st_addr: if (s_req_ready) w_next = c_st_data;
            c_st_data: begin
                // A real response in the timeout cycle takes precedence.
                if (w_resp_done)
                    w_next = c_st_idle;
                else if (w_tmo)
                    w_next = c_st_terr;
            end
            c_st_terr: if (w_own_rready) w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            if (w_hs) begin
                r_owner <= w_win;
                r_addr  <= w_win ? m1_addr  : m0_addr;
                r_wen   <= w_win ? m1_wen   : m0_wen;
                r_wdata <= w_win ? m1_wdata : m0_wdata;
                r_wmask <= w_win ? m1_wmask : m0_wmask;
            end
            if ((r_state == c_st_addr) && s_req_ready)
                r_cnt <= '0;
            else if ((r_state == c_st_data) && (r_cnt != '1))
                r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_resp_done | w_terr_done)
                r_last <= r_owner;
        end
    end

    assign s_addr  = r_addr;
    assign s_wen   = r_wen;
    assign s_wdata = r_wdata;
    assign s_wmask = r_wmask;

    always_comb begin
        m0_req_ready = w_hs & ~w_win;
        m1_req_ready = w_hs &  w_win;
        s_req_valid  = 1'b0;
        s_resp_ready = 1'b1;
        grant        = 2'b00;
        w_rvalid     = 1'b0;
        w_rdata      = '0;
        w_err        = 1'b0;
        case (r_state)
            c_st_addr: begin
                s_req_valid = 1'b1;
                grant       = {r_owner, ~r_owner};
            end
            c_st_data: begin
                grant        = {r_owner, ~r_owner};
                s_resp_ready = w_own_rready;
                w_rvalid     = s_resp_valid;
                w_rdata      = s_resp_valid ? s_rdata : '0;
                w_err        = s_resp_valid & s_err;
            end
            c_st_terr: begin
                grant    = {r_owner, ~r_owner};
                w_rvalid = 1'b1;
                w_err    = 1'b1;
            end
            default: ;
        endcase
        m0_resp_valid = w_rvalid & ~r_owner;
        m1_resp_valid = w_rvalid &  r_owner;
        m0_rdata      = r_owner ? '0 : w_rdata;
        m1_rdata      = r_owner ? w_rdata : '0;
        m0_err        = w_err & ~r_owner;
        m1_err        = w_err &  r_owner;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (RR and fixed-priority builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst2;
    logic [1:0]       t_req_valid, t_wen, t_resp_ready;
    logic [1:0][31:0] t_addr, t_wdata;
    logic [1:0][3:0]  t_wmask;
    logic             s_req_ready, s_resp_valid, s_err;
    logic [31:0]      s_rdata;
    logic [31:0]      fix_rdata;

    wire [1:0]       d1_req_ready, d1_resp_valid, d1_err, d1_grant;
    wire [1:0][31:0] d1_rdata;
    wire             d1_s_req_valid, d1_s_wen, d1_s_resp_ready;
    wire [31:0]      d1_s_addr, d1_s_wdata;
    wire [3:0]       d1_s_wmask;

    wire [1:0]       d2_req_ready, d2_resp_valid, d2_err, d2_grant;
    wire [1:0][31:0] d2_rdata;
    wire             d2_s_req_valid, d2_s_wen, d2_s_resp_ready;
    wire [31:0]      d2_s_addr, d2_s_wdata;
    wire [3:0]       d2_s_wmask;

    mem_arbiter #(.WIDTH(32), .RR(1'b1), .TIMEOUT(TMO)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req_valid(t_req_valid[0]), .m0_req_ready(d1_req_ready[0]),
        .m0_addr(t_addr[0]), .m0_wen(t_wen[0]), .m0_wdata(t_wdata[0]), .m0_wmask(t_wmask[0]),
        .m0_resp_valid(d1_resp_valid[0]), .m0_resp_ready(t_resp_ready[0]),
        .m0_rdata(d1_rdata[0]), .m0_err(d1_err[0]),
        .m1_req_valid(t_req_valid[1]), .m1_req_ready(d1_req_ready[1]),
        .m1_addr(t_addr[1]), .m1_wen(t_wen[1]), .m1_wdata(t_wdata[1]), .m1_wmask(t_wmask[1]),
        .m1_resp_valid(d1_resp_valid[1]), .m1_resp_ready(t_resp_ready[1]),
        .m1_rdata(d1_rdata[1]), .m1_err(d1_err[1]),
        .s_req_valid(d1_s_req_valid), .s_req_ready(s_req_ready),
        .s_addr(d1_s_addr), .s_wen(d1_s_wen), .s_wdata(d1_s_wdata), .s_wmask(d1_s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(d1_s_resp_ready),
        .s_rdata(s_rdata), .s_err(s_err), .grant(d1_grant)
    );

    mem_arbiter #(.WIDTH(32), .RR(1'b0), .TIMEOUT(TMO)) u_fp (
        .clk(clk), .rst(rst2),
        .m0_req_valid(t_req_valid[0]), .m0_req_ready(d2_req_ready[0]),
        .m0_addr(t_addr[0]), .m0_wen(t_wen[0]), .m0_wdata(t_wdata[0]), .m0_wmask(t_wmask[0]),
        .m0_resp_valid(d2_resp_valid[0]), .m0_resp_ready(t_resp_ready[0]),
        .m0_rdata(d2_rdata[0]), .m0_err(d2_err[0]),
        .m1_req_valid(t_req_valid[1]), .m1_req_ready(d2_req_ready[1]),
        .m1_addr(t_addr[1]), .m1_wen(t_wen[1]), .m1_wdata(t_wdata[1]), .m1_wmask(t_wmask[1]),
        .m1_resp_valid(d2_resp_valid[1]), .m1_resp_ready(t_resp_ready[1]),
        .m1_rdata(d2_rdata[1]), .m1_err(d2_err[1]),
        .s_req_valid(d2_s_req_valid), .s_req_ready(s_req_ready),
        .s_addr(d2_s_addr), .s_wen(d2_s_wen), .s_wdata(d2_s_wdata), .s_wmask(d2_s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(d2_s_resp_ready),
        .s_rdata(s_rdata), .s_err(s_err), .grant(d2_grant)
    );

    int n_checks = 0;
    int n_err    = 0;
    int exp_last = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration rule: lone requester wins; ties go to m1 (fixed)
    // or to the master not served last (round-robin).
    function automatic int pick(input bit v0, input bit v1, input int last, input bit rr);
        if (v0 && v1) return rr ? 1 - last : 1;
        return v1 ? 1 : 0;
    endfunction

    function automatic logic [1:0] oh(input int w);
        return (w != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the round-robin build. aw = ADDR stall cycles,
    // rw = DATA cycle the slave first responds, st = DATA cycles owner is not ready.
    task automatic run_txn(input bit v0, input bit v1, input int aw, input int rw,
                           input int st, input bit fixed);
        int w;
        bit rv, ro, done, in_terr;
        logic [31:0] ea, ewd;
        logic ewe;
        logic [3:0] ewm;
        if (!fixed) begin
            for (int m = 0; m < 2; m++) begin
                t_addr[m]  = $urandom;
                t_wen[m]   = 1'($urandom_range(0, 1));
                t_wdata[m] = $urandom;
                t_wmask[m] = 4'($urandom_range(0, 15));
            end
        end
        t_req_valid  = {v1, v0};
        s_req_ready  = 1'($urandom_range(0, 1));
        s_resp_valid = 1'($urandom_range(0, 1));
        s_rdata      = $urandom;
        s_err        = 1'($urandom_range(0, 1));
        t_resp_ready = 2'($urandom_range(0, 3));
        w   = pick(v0, v1, exp_last, 1'b1);
        ea  = t_addr[w];
        ewd = t_wdata[w];
        ewe = t_wen[w];
        ewm = t_wmask[w];
        #1;
        chk("idle_req_ready", d1_req_ready, oh(w));
        chk("idle_grant", d1_grant, 2'b00);
        chk("idle_resp", {d1_resp_valid, d1_err}, 4'b0);
        chk("idle_s_req_valid", d1_s_req_valid, 1'b0);
        chk("idle_s_resp_ready", d1_s_resp_ready, 1'b1);
        tick();
        t_req_valid[w] = 1'b0;
        for (int k = 0; k <= aw; k++) begin
            s_req_ready  = (k == aw);
            s_resp_valid = 1'($urandom_range(0, 1));
            s_rdata      = $urandom;
            t_resp_ready = 2'($urandom_range(0, 3));
            t_addr[w]    = $urandom;
            t_wdata[w]   = $urandom;
            #1;
            chk("addr_s_req_valid", d1_s_req_valid, 1'b1);
            chk("addr_fields", {d1_s_wen, d1_s_wmask, d1_s_addr}, {ewe, ewm, ea});
            chk("addr_wdata", d1_s_wdata, ewd);
            chk("addr_grant", d1_grant, oh(w));
            chk("addr_resp", {d1_resp_valid, d1_req_ready}, 4'b0);
            chk("addr_s_resp_ready", d1_s_resp_ready, 1'b1);
            tick();
        end
        s_req_ready = 1'b0;
        in_terr = 1'b0;
        for (int c = 0; c < 64; c++) begin
            rv = (c >= rw);
            ro = (c >= st);
            s_resp_valid = rv;
            s_rdata      = (fixed && rv) ? fix_rdata : $urandom;
            s_err        = fixed ? 1'b0 : 1'($urandom_range(0, 1));
            t_resp_ready[w]     = ro;
            t_resp_ready[1 - w] = 1'($urandom_range(0, 1));
            #1;
            chk("busy_grant", d1_grant, oh(w));
            chk("busy_req_ready", d1_req_ready, 2'b00);
            if (!in_terr) begin
                chk("data_resp_valid", d1_resp_valid, rv ? oh(w) : 2'b00);
                chk("data_rdata", d1_rdata[w], rv ? s_rdata : 32'h0);
                chk("data_err", d1_err[w], rv ? s_err : 1'b0);
                chk("data_s_resp_ready", d1_s_resp_ready, ro);
                done = rv && ro;
            end else begin
                chk("terr_resp_valid", d1_resp_valid, oh(w));
                chk("terr_rdata_err", {d1_rdata[w], d1_err[w]}, {32'h0, 1'b1});
                chk("terr_s_resp_ready", d1_s_resp_ready, 1'b1);
                done = ro;
            end
            chk("nonowner_resp", {d1_rdata[1 - w], d1_err[1 - w]}, 33'h0);
            tick();
            if (done) break;
            if (c == TMO - 1) in_terr = 1'b1;
        end
        exp_last     = w;
        s_resp_valid = 1'b0;
        t_resp_ready = 2'b00;
    endtask

    task automatic idle_stray();
        t_req_valid  = 2'b00;
        s_resp_valid = 1'b1;
        s_rdata      = $urandom;
        s_err        = 1'b1;
        t_resp_ready = 2'b11;
        #1;
        chk("stray_resp", {d1_resp_valid, d1_err}, 4'b0);
        chk("stray_s_resp_ready", d1_s_resp_ready, 1'b1);
        chk("stray_grant", d1_grant, 2'b00);
        tick();
        s_resp_valid = 1'b0;
    endtask

    initial begin
        int n0, n1, w;
        rst = 1'b1; rst2 = 1'b1;
        t_req_valid = '0; t_wen = '0; t_resp_ready = '0;
        t_addr = '0; t_wdata = '0; t_wmask = '0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_err = 1'b0; s_rdata = '0;
        fix_rdata = 32'h0;

        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_valids", {d1_s_req_valid, d1_resp_valid, d1_req_ready}, 5'b0);
            chk("rst_grant", d1_grant, 2'b00);
            chk("rst_s_resp_ready", d1_s_resp_ready, 1'b1);
        end
        rst = 1'b0;
        exp_last = 0;

        // Minimum-latency m0 read.
        t_addr[0] = 32'h8000_0000; t_wen[0] = 1'b0; t_wdata[0] = 32'h0; t_wmask[0] = 4'h0;
        fix_rdata = 32'hDEAD_BEEF;
        run_txn(1'b1, 1'b0, 0, 0, 0, 1'b1);

        // m1 write with the slave stalling the request for 5 cycles.
        t_addr[1] = 32'h8000_0010; t_wen[1] = 1'b1; t_wdata[1] = 32'h1234_5678; t_wmask[1] = 4'hF;
        fix_rdata = 32'h0;
        run_txn(1'b0, 1'b1, 5, 2, 0, 1'b1);

        // Both masters contending: grants must alternate.
        for (int k = 0; k < 8; k++) run_txn(1'b1, 1'b1, 0, 0, 0, 1'b0);

        // Timeout, late stray response, and timeout-boundary races.
        run_txn(1'b1, 1'b0, 0, 50, 0, 1'b0);
        idle_stray();
        run_txn(1'b0, 1'b1, 1, TMO - 1, 0, 1'b0);
        run_txn(1'b1, 1'b0, 0, TMO, 0, 1'b0);
        run_txn(1'b0, 1'b1, 0, 0, TMO + 1, 1'b0);
        idle_stray();

        // Master backpressure in DATA.
        run_txn(1'b1, 1'b0, 0, 0, 3, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int v;
            v = $urandom_range(1, 3);
            run_txn(v[0], v[1], $urandom_range(0, 3), $urandom_range(0, 10),
                    $urandom_range(0, 10), 1'b0);
        end

        // Reset while in DATA aborts the transaction silently.
        t_req_valid = 2'b01;
        t_addr[0] = $urandom;
        #1;
        chk("rstd_hs", d1_req_ready, 2'b01);
        tick();
        t_req_valid = 2'b00; s_req_ready = 1'b1;
        tick();
        s_req_ready = 1'b0; s_resp_valid = 1'b0; t_resp_ready = 2'b11;
        #1;
        chk("rstd_pre_grant", d1_grant, 2'b01);
        rst = 1'b1;
        tick();
        s_resp_valid = 1'b1;
        #1;
        chk("rstd_grant", d1_grant, 2'b00);
        chk("rstd_resp", {d1_resp_valid, d1_s_req_valid}, 3'b0);
        chk("rstd_s_resp_ready", d1_s_resp_ready, 1'b1);
        rst = 1'b0;
        s_resp_valid = 1'b0;
        exp_last = 0;
        run_txn(1'b1, 1'b0, 1, 2, 0, 1'b0);

        // Fixed-priority build: m1 must be served 4 times before m0.
        rst = 1'b1;
        tick();
        rst2 = 1'b0;
        s_req_ready = 1'b1; s_resp_valid = 1'b1; s_err = 1'b0; t_resp_ready = 2'b11;
        n0 = 4; n1 = 4;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ea, ewd;
            logic ewe;
            logic [3:0] ewm;
            w = pick(n0 > 0, n1 > 0, 0, 1'b0);
            t_req_valid = {n1 > 0, n0 > 0};
            for (int m = 0; m < 2; m++) begin
                t_addr[m]  = $urandom;
                t_wen[m]   = 1'($urandom_range(0, 1));
                t_wdata[m] = $urandom;
                t_wmask[m] = 4'($urandom_range(0, 15));
            end
            ea = t_addr[w]; ewd = t_wdata[w]; ewe = t_wen[w]; ewm = t_wmask[w];
            s_rdata = $urandom;
            #1;
            chk("fp_req_ready", d2_req_ready, oh(w));
            tick();
            if (w != 0) n1--; else n0--;
            t_req_valid = {n1 > 0, n0 > 0};
            #1;
            chk("fp_addr", {d2_s_req_valid, d2_grant}, {1'b1, oh(w)});
            chk("fp_fields", {d2_s_wen, d2_s_wmask, d2_s_addr}, {ewe, ewm, ea});
            chk("fp_wdata", d2_s_wdata, ewd);
            tick();
            #1;
            chk("fp_resp", {d2_resp_valid, d2_err}, {oh(w), 2'b00});
            chk("fp_rdata", d2_rdata[w], s_rdata);
            chk("fp_s_resp_ready", d2_s_resp_ready, 1'b1);
            tick();
        end
        rst2 = 1'b1;
        t_req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
